// File: rtl/cm0ik_misc_delay_pkg.sv
// cm0ik_misc_delay_pkg: width helpers, modular pointer subtraction and delay legality for the delay line
package cm0ik_misc_delay_pkg;
  function automatic int dly_w(input int max_d);
    return $clog2(max_d + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic int ptr_sub(input int wptr, input int d, input int depth);
    return (wptr >= d) ? wptr - d : wptr + depth - d;
  endfunction
  function automatic logic dly_ok(input int d, input int max_d);
    return (d >= 1) && (d <= max_d);
  endfunction
endpackage

// File: rtl/cm0ik_misc_delay_ram.sv
// cm0ik_misc_delay_ram: DEPTH x WIDTH register array, synchronous write, asynchronous read
module cm0ik_misc_delay_ram #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 24,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cm0ik_misc_delay_line.sv
// cm0ik_misc_delay_line: runtime-programmable WIDTH-bit delay line; CM0IK_MISC_DELAY_FILLED_EN adds the filled port
module cm0ik_misc_delay_line
  import cm0ik_misc_delay_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MAX_DELAY = 24,
  parameter int DEFAULT_DELAY = 24,
  localparam int DLY_W = dly_w(MAX_DELAY),
  localparam int PTR_W = ptr_w(MAX_DELAY)
) (
  input  logic             fclk,
  input  logic             hresetn,
  input  logic             tick,
  input  logic [DLY_W-1:0] dly,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic             dly_err
`ifdef CM0IK_MISC_DELAY_FILLED_EN
  ,
  output logic             filled
`endif
);
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr;
  logic [DLY_W-1:0] fill_q, fill_d, cur_dly_q, cur_dly_d;
  logic             err_q, err_d, legal, chg, valid;
  logic [WIDTH-1:0] rdata;
  always_comb begin
    legal     = dly_ok(int'(dly), MAX_DELAY);
    chg       = legal && (dly != cur_dly_q);
    wptr_d    = !tick ? wptr_q : (wptr_q == PTR_W'(MAX_DELAY - 1)) ? '0 : wptr_q + PTR_W'(1);
    // a delay change restarts the fill even on a tick cycle
    fill_d    = chg ? '0 : (tick && fill_q != DLY_W'(MAX_DELAY)) ? fill_q + DLY_W'(1) : fill_q;
    cur_dly_d = chg ? dly : cur_dly_q;
    err_d     = !legal;
  end
  always_ff @(posedge fclk) begin
    if (!hresetn) begin
      wptr_q    <= '0;
      fill_q    <= '0;
      cur_dly_q <= DLY_W'(DEFAULT_DELAY);
      err_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      cur_dly_q <= cur_dly_d;
      err_q     <= err_d;
    end
  end
  assign rptr = PTR_W'(ptr_sub(int'(wptr_q), int'(cur_dly_q), MAX_DELAY));
  cm0ik_misc_delay_ram #(.WIDTH(WIDTH), .DEPTH(MAX_DELAY), .PTR_W(PTR_W)) u_ram (
    .clk    (fclk),
    .we_i   (tick),
    .waddr_i(wptr_q),
    .wdata_i(i),
    .raddr_i(rptr),
    .rdata_o(rdata)
  );
  assign valid   = fill_q >= cur_dly_q;
  assign o       = valid ? rdata : '0;
  assign dly_err = err_q;
`ifdef CM0IK_MISC_DELAY_FILLED_EN
  assign filled  = valid;
`endif
endmodule

// File: tb/tb_cm0ik_misc_delay_line.sv
// tb_cm0ik_misc_delay_line: directed bench for a default 1x24 line and an 8-bit x 7 line driven side by side
module tb_cm0ik_misc_delay_line;
  logic       fclk, hresetn;
  logic       t0, t1, i0, o0, e0, o1_unused;
  logic [4:0] d0;
  logic [2:0] d1;
  logic [7:0] i1, o1;
  logic       e1;
`ifdef CM0IK_MISC_DELAY_FILLED_EN
  logic       fl0, fl1;
`endif
  int n_run = 0, n_fail = 0;
  int f0, c0, f1, c1;
  logic ee0, ee1;
  logic w0[$];
  logic [7:0] w1[$];
  logic [31:0] pat = 32'hB5C3_1E6D;
  logic [7:0] cnt = 8'd0;

  cm0ik_misc_delay_line u0 (
    .fclk(fclk), .hresetn(hresetn), .tick(t0), .dly(d0), .i(i0), .o(o0), .dly_err(e0)
`ifdef CM0IK_MISC_DELAY_FILLED_EN
    , .filled(fl0)
`endif
  );
  cm0ik_misc_delay_line #(.WIDTH(8), .MAX_DELAY(7), .DEFAULT_DELAY(7)) u1 (
    .fclk(fclk), .hresetn(hresetn), .tick(t1), .dly(d1), .i(i1), .o(o1), .dly_err(e1)
`ifdef CM0IK_MISC_DELAY_FILLED_EN
    , .filled(fl1)
`endif
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock edge; the reference history is updated with the inputs sampled at that edge
  task automatic step();
    @(posedge fclk);
    if (!hresetn) begin
      f0 = 0; c0 = 24; ee0 = 1'b0;
      f1 = 0; c1 = 7;  ee1 = 1'b0;
    end else begin
      if (t0) begin w0.push_back(i0); f0 = (f0 < 24) ? f0 + 1 : 24; end
      if (t1) begin w1.push_back(i1); f1 = (f1 < 7) ? f1 + 1 : 7; end
      ee0 = !(d0 >= 1 && d0 <= 24);
      ee1 = !(d1 >= 1 && d1 <= 7);
      if (!ee0 && int'(d0) != c0) begin c0 = int'(d0); f0 = 0; end
      if (!ee1 && int'(d1) != c1) begin c1 = int'(d1); f1 = 0; end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] x0, x1;
    x0 = (f0 >= c0) ? 32'(w0[w0.size() - c0]) : 32'd0;
    x1 = (f1 >= c1) ? 32'(w1[w1.size() - c1]) : 32'd0;
    check({tag, ".o0"}, 32'(o0), x0);
    check({tag, ".e0"}, 32'(e0), 32'(ee0));
    check({tag, ".o1"}, 32'(o1), x1);
    check({tag, ".e1"}, 32'(e1), 32'(ee1));
`ifdef CM0IK_MISC_DELAY_FILLED_EN
    check({tag, ".fl0"}, 32'(fl0), 32'(f0 >= c0));
    check({tag, ".fl1"}, 32'(fl1), 32'(f1 >= c1));
`endif
  endtask

  task automatic cyc(input string tag, input logic nd);
    i0 = nd;
    i1 = cnt;
    cnt = cnt + 8'd1;
    step();
    check_all(tag);
  endtask

  initial begin
    o1_unused = 1'b0;
    hresetn = 1'b0; t0 = 1'b0; t1 = 1'b0; d0 = 5'd24; d1 = 3'd7; i0 = 1'b0; i1 = 8'd0;
    step();
    step();
    check("rst.o0", 32'(o0), 32'd0);
    check("rst.e0", 32'(e0), 32'd0);
    check("rst.o1", 32'(o1), 32'd0);
    hresetn = 1'b1; t0 = 1'b1; t1 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      cyc("t1", n[0]);
      if (n == 23) check("t1.edge23", 32'(o0), 32'd0);
      if (n == 24) check("t1.edge24", 32'(o0), 32'd1);
      if (n == 25) check("t1.edge25", 32'(o0), 32'd0);
    end
    d0 = 5'd0;
    cyc("t4a", pat[0]);
    check("t4.err_zero", 32'(e0), 32'd1);
    d0 = 5'd25;
    cyc("t4b", pat[1]);
    check("t4.err_over", 32'(e0), 32'd1);
    d0 = 5'd24;
    cyc("t4c", pat[2]);
    check("t4.err_clr", 32'(e0), 32'd0);
    d0 = 5'd5;
    for (int k = 0; k < 14; k++) begin
      cyc("t3a", pat[k % 32]);
      if (k == 4) check("t3.still_zero", 32'(o0), 32'd0);
    end
    d0 = 5'd20;
    for (int k = 0; k < 30; k++) cyc("t3b", pat[(k + 7) % 32]);
    d0 = 5'd4;
    for (int k = 0; k < 36; k++) begin
      t0 = (k % 3 == 0);
      cyc("t2", pat[(k * 5) % 32]);
    end
    t0 = 1'b1;
    d1 = 3'd0;
    cyc("t5err", 1'b0);
    check("t5.err1", 32'(e1), 32'd1);
    d1 = 3'd7;
    for (int k = 0; k < 30; k++) cyc("t5a", 1'b1);
    d1 = 3'd1;
    cyc("t5b0", 1'b0);
    check("t5.d1_zero", 32'(o1), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc("t5b", 1'b0);
      check("t5.prev_i", 32'(o1), 32'(i1));
    end
    d0 = 5'd24; d1 = 3'd7;
    for (int k = 0; k < 30; k++) cyc("t6a", pat[(k * 3) % 32]);
    hresetn = 1'b0;
    cyc("t6rst", 1'b1);
    check("t6.o0_rst", 32'(o0), 32'd0);
    hresetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc("t6b", 1'b1);
      if (k == 22) check("t6.refill23", 32'(o0), 32'd0);
      if (k == 23) check("t6.refill24", 32'(o0), 32'd1);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
